// File: rtl/traffic_pkg.sv
// traffic_pkg: shared light encodings, default load counts and checker error codes
package traffic_pkg;
  typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2, ILLEGAL = 2'd3} light_t;
  typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} chk_state_t;
  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_ILLEGAL = 2'd1, ERR_STATE = 2'd2, ERR_COUNT = 2'd3} err_code_t;
  localparam int DEF_RED_COUNT = 3;
  localparam int DEF_GREEN_COUNT = 4;
  localparam int DEF_YELLOW_COUNT = 2;
  function automatic light_t next_light(input light_t s);
    return s == RED ? GREEN : s == GREEN ? YELLOW : RED;
  endfunction
endpackage

// File: rtl/traffic_next_expect.sv
// traffic_next_expect: combinational successor of a (light, countdown) pair
module traffic_next_expect import traffic_pkg::*; #(
  parameter int RED_COUNT = DEF_RED_COUNT,
  parameter int GREEN_COUNT = DEF_GREEN_COUNT,
  parameter int YELLOW_COUNT = DEF_YELLOW_COUNT
) (
  input  light_t     cur_state,
  input  logic [3:0] cur_count,
  output light_t     nxt_state,
  output logic [3:0] nxt_count
);
  light_t succ;
  logic [3:0] succ_load;
  always_comb begin
    succ = next_light(cur_state);
    succ_load = succ == RED ? 4'(RED_COUNT) : succ == GREEN ? 4'(GREEN_COUNT) : 4'(YELLOW_COUNT);
    nxt_state = cur_count != 4'd0 ? cur_state : succ;
    nxt_count = cur_count != 4'd0 ? cur_count - 4'd1 : succ_load;
  end
endmodule

// File: rtl/traffic_seq_checker.sv
// traffic_seq_checker: locks onto an observed traffic-light stream and flags sequence errors
module traffic_seq_checker import traffic_pkg::*; #(
  parameter int RED_COUNT = DEF_RED_COUNT,
  parameter int GREEN_COUNT = DEF_GREEN_COUNT,
  parameter int YELLOW_COUNT = DEF_YELLOW_COUNT
) (
  input  logic       clk_1hz,
  input  logic       rst,
  input  logic [1:0] state_in,
  input  logic [3:0] countdown_in,
  input  logic       clr_err,
  output logic       locked,
  output logic       err_pulse,
  output logic [1:0] err_code,
  output logic       err_sticky,
  output logic [3:0] err_count,
  output logic [7:0] cycle_count
);
  chk_state_t state_q, state_d;
  light_t exp_state_q, exp_state_d, nxt_state, sample_state;
  logic [3:0] exp_count_q, exp_count_d, nxt_count, load_in;
  logic locked_q, locked_d, err_pulse_q, err_pulse_d, err_sticky_q, err_sticky_d;
  err_code_t err_code_q, err_code_d, code;
  logic [3:0] err_count_q, err_count_d;
  logic [7:0] cycle_count_q, cycle_count_d;
  logic legal, lock_ok, match, err, wrap;
  assign sample_state = light_t'(state_in);
  // In TRACK the expectation only advances on a match, so the sample itself
  // can feed the successor logic in both states.
  traffic_next_expect #(
    .RED_COUNT(RED_COUNT), .GREEN_COUNT(GREEN_COUNT), .YELLOW_COUNT(YELLOW_COUNT)
  ) u_next (
    .cur_state(sample_state),
    .cur_count(countdown_in),
    .nxt_state(nxt_state),
    .nxt_count(nxt_count)
  );
  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) begin
      state_q       <= SYNC;
      exp_state_q   <= RED;
      exp_count_q   <= 4'(RED_COUNT);
      locked_q      <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      err_sticky_q  <= 1'b0;
      err_count_q   <= 4'd0;
      cycle_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      exp_state_q   <= exp_state_d;
      exp_count_q   <= exp_count_d;
      locked_q      <= locked_d;
      err_pulse_q   <= err_pulse_d;
      err_code_q    <= err_code_d;
      err_sticky_q  <= err_sticky_d;
      err_count_q   <= err_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end
  always_comb begin
    legal = sample_state != ILLEGAL;
    load_in = sample_state == RED ? 4'(RED_COUNT) : sample_state == GREEN ? 4'(GREEN_COUNT) : 4'(YELLOW_COUNT);
    lock_ok = legal && countdown_in == load_in;
    match = sample_state == exp_state_q && countdown_in == exp_count_q;
    state_d = state_q == SYNC ? (lock_ok ? TRACK : SYNC) : (match ? TRACK : SYNC);
  end
  always_comb begin
    err = state_q == SYNC ? !legal : !match;
    code = !legal ? ERR_ILLEGAL : sample_state != exp_state_q ? ERR_STATE : ERR_COUNT;
    // A matched (RED, RED_COUNT) in TRACK can only follow an expected YELLOW zero.
    wrap = state_q == TRACK && match && sample_state == RED && countdown_in == 4'(RED_COUNT);
    exp_state_d = state_d == TRACK ? nxt_state : exp_state_q;
    exp_count_d = state_d == TRACK ? nxt_count : exp_count_q;
    locked_d = state_d == TRACK;
    err_pulse_d = err;
    err_code_d = err ? code : clr_err ? ERR_NONE : err_code_q;
    err_sticky_d = err | (err_sticky_q & ~clr_err);
    err_count_d = err ? (clr_err ? 4'd1 : err_count_q == 4'hF ? 4'hF : err_count_q + 4'd1)
                      : (clr_err ? 4'd0 : err_count_q);
    cycle_count_d = cycle_count_q + 8'(wrap);
  end
  assign locked      = locked_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;
  assign err_sticky  = err_sticky_q;
  assign err_count   = err_count_q;
  assign cycle_count = cycle_count_q;
endmodule

// File: tb/tb_traffic_seq_checker.sv
// tb_traffic_seq_checker: scoreboard bench comparing the checker against a behavioural model
module tb_traffic_seq_checker;
  localparam int RC = 3, GC = 4, YC = 2;
  logic clk_1hz = 1'b0, rst = 1'b1, clr_err = 1'b0;
  logic [1:0] state_in = 2'd0;
  logic [3:0] countdown_in = 4'd0;
  logic locked, err_pulse, err_sticky;
  logic [1:0] err_code;
  logic [3:0] err_count;
  logic [7:0] cycle_count;
  int n_checks = 0, n_fail = 0;

  typedef struct packed {
    logic       locked;
    logic       pulse;
    logic [1:0] code;
    logic       sticky;
    logic [3:0] cnt;
    logic [7:0] cyc;
  } exp_t;
  exp_t sb[$];

  logic       m_locked;
  logic [1:0] m_exp_s, m_prev_s, m_code;
  logic [3:0] m_exp_c, m_cnt;
  logic       m_sticky;
  logic [7:0] m_cyc;

  traffic_seq_checker #(.RED_COUNT(RC), .GREEN_COUNT(GC), .YELLOW_COUNT(YC)) dut (
    .clk_1hz(clk_1hz), .rst(rst), .state_in(state_in), .countdown_in(countdown_in),
    .clr_err(clr_err), .locked(locked), .err_pulse(err_pulse), .err_code(err_code),
    .err_sticky(err_sticky), .err_count(err_count), .cycle_count(cycle_count)
  );

  always #5 clk_1hz = ~clk_1hz;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] load_of(input logic [1:0] s);
    case (s)
      2'd0: return 4'(RC);
      2'd1: return 4'(GC);
      default: return 4'(YC);
    endcase
  endfunction

  task automatic model_reset();
    m_locked = 0; m_exp_s = 2'd0; m_exp_c = 4'(RC); m_prev_s = 2'd0;
    m_code = 0; m_sticky = 0; m_cnt = 0; m_cyc = 0;
  endtask

  task automatic model_advance(input logic [1:0] s, input logic [3:0] c);
    m_prev_s = s;
    if (c > 0) begin
      m_exp_s = s; m_exp_c = c - 1;
    end else begin
      m_exp_s = (s == 2'd0) ? 2'd1 : (s == 2'd1) ? 2'd2 : 2'd0;
      m_exp_c = load_of(m_exp_s);
    end
  endtask

  task automatic model_step(input logic [1:0] s, input logic [3:0] c, input logic clr, output exp_t e);
    logic err;
    logic [1:0] code;
    err = 0; code = 0;
    if (!m_locked) begin
      if (s == 2'd3) begin err = 1; code = 1; end
      else if (c == load_of(s)) begin m_locked = 1; model_advance(s, c); end
    end else if (s == m_exp_s && c == m_exp_c) begin
      if (s == 2'd0 && c == 4'(RC) && m_prev_s == 2'd2) m_cyc = m_cyc + 1;
      model_advance(s, c);
    end else begin
      m_locked = 0; err = 1;
      code = (s == 2'd3) ? 2'd1 : (s != m_exp_s) ? 2'd2 : 2'd3;
    end
    if (err) begin
      m_code = code; m_sticky = 1;
      m_cnt = clr ? 4'd1 : (m_cnt == 4'd15 ? 4'd15 : m_cnt + 1);
    end else if (clr) begin
      m_code = 0; m_sticky = 0; m_cnt = 0;
    end
    e = '{locked: m_locked, pulse: err, code: m_code, sticky: m_sticky, cnt: m_cnt, cyc: m_cyc};
  endtask

  task automatic apply(input logic [1:0] s, input logic [3:0] c, input logic clr);
    exp_t e;
    @(negedge clk_1hz);
    state_in = s; countdown_in = c; clr_err = clr;
    model_step(s, c, clr, e);
    sb.push_back(e);
    @(posedge clk_1hz);
    #2;
    clr_err = 1'b0;
  endtask

  // Monitor: one scoreboard entry per clock edge, compared shortly after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_1hz);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (locked !== e.locked) begin n_fail++; $display("FAIL sb_locked: got %b expected %b at %0t", locked, e.locked, $time); end
        n_checks++;
        if (err_pulse !== e.pulse) begin n_fail++; $display("FAIL sb_err_pulse: got %b expected %b at %0t", err_pulse, e.pulse, $time); end
        n_checks++;
        if (err_code !== e.code) begin n_fail++; $display("FAIL sb_err_code: got %0d expected %0d at %0t", err_code, e.code, $time); end
        n_checks++;
        if (err_sticky !== e.sticky) begin n_fail++; $display("FAIL sb_err_sticky: got %b expected %b at %0t", err_sticky, e.sticky, $time); end
        n_checks++;
        if (err_count !== e.cnt) begin n_fail++; $display("FAIL sb_err_count: got %0d expected %0d at %0t", err_count, e.cnt, $time); end
        n_checks++;
        if (cycle_count !== e.cyc) begin n_fail++; $display("FAIL sb_cycle_count: got %0d expected %0d at %0t", cycle_count, e.cyc, $time); end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #2;
    n_checks++;
    if ({locked, err_pulse, err_code, err_sticky, err_count, cycle_count} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero", {locked, err_pulse, err_code, err_sticky, err_count, cycle_count});
    end
    repeat (2) @(posedge clk_1hz);
    @(negedge clk_1hz);
    rst = 1'b0;
  endtask

  task automatic test_golden();
    apply(2'd0, 4'd3, 0);
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL golden_lock: got %b expected 1", locked); end
    for (int c = 2; c >= 0; c--) apply(2'd0, 4'(c), 0);
    for (int c = GC; c >= 0; c--) apply(2'd1, 4'(c), 0);
    for (int c = YC; c >= 0; c--) apply(2'd2, 4'(c), 0);
    apply(2'd0, 4'd3, 0);
    n_checks++;
    if (cycle_count !== 8'd1) begin n_fail++; $display("FAIL golden_cycle: got %0d expected 1", cycle_count); end
  endtask

  task automatic test_count_mismatch();
    apply(2'd0, 4'd2, 0); apply(2'd0, 4'd1, 0); apply(2'd0, 4'd0, 0); apply(2'd1, 4'd4, 0);
    apply(2'd1, 4'd2, 0);
    n_checks++;
    if (err_code !== 2'd3 || err_pulse !== 1'b1) begin
      n_fail++; $display("FAIL count_mismatch: got code %0d pulse %b expected code 3 pulse 1", err_code, err_pulse);
    end
    apply(2'd1, 4'd4, 0);
    n_checks++;
    if (locked !== 1'b1 || err_pulse !== 1'b0) begin
      n_fail++; $display("FAIL count_relock: got locked %b pulse %b expected 1 0", locked, err_pulse);
    end
  endtask

  task automatic test_illegal_and_state();
    apply(2'd1, 4'd3, 1);
    apply(2'd3, 4'd2, 0);
    n_checks++;
    if (err_code !== 2'd1 || err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL illegal: got code %0d sticky %b expected 1 1", err_code, err_sticky);
    end
    apply(2'd0, 4'd1, 0);
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL no_lock_r1: got locked %b expected 0", locked); end
    apply(2'd3, 4'd0, 0);
    apply(2'd0, 4'd3, 0);
    apply(2'd1, 4'd2, 0);
    n_checks++;
    if (err_code !== 2'd2) begin n_fail++; $display("FAIL state_mismatch: got code %0d expected 2", err_code); end
  endtask

  task automatic test_saturation();
    apply(2'd0, 4'd1, 1);
    for (int i = 0; i < 17; i++) begin
      apply(2'd1, 4'd4, 0);
      apply(2'd1, 4'd0, 0);
    end
    n_checks++;
    if (err_count !== 4'd15) begin n_fail++; $display("FAIL saturate: got %0d expected 15", err_count); end
    apply(2'd0, 4'd1, 1);
    n_checks++;
    if (err_count !== 4'd0 || err_sticky !== 1'b0 || err_code !== 2'd0) begin
      n_fail++; $display("FAIL clr_err: got cnt %0d sticky %b code %0d expected 0 0 0", err_count, err_sticky, err_code);
    end
  endtask

  task automatic test_clr_coincide();
    apply(2'd0, 4'd3, 0);
    apply(2'd0, 4'd2, 1);
    apply(2'd0, 4'd0, 1);
    n_checks++;
    if (err_sticky !== 1'b1 || err_count !== 4'd1 || err_code !== 2'd3) begin
      n_fail++; $display("FAIL clr_coincide: got sticky %b cnt %0d code %0d expected 1 1 3", err_sticky, err_count, err_code);
    end
  endtask

  task automatic test_back_to_back();
    apply(2'd2, 4'd2, 0);
    apply(2'd2, 4'd1, 1);
    apply(2'd2, 4'd0, 0);
    apply(2'd0, 4'd3, 1);
    apply(2'd0, 4'd2, 0);
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL b2b_locked: got %b expected 1", locked); end
  endtask

  task automatic test_reset_mid();
    apply(2'd3, 4'd0, 0);
    apply(2'd1, 4'd4, 0); apply(2'd1, 4'd3, 0); apply(2'd1, 4'd2, 0);
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({locked, err_pulse, err_code, err_sticky, err_count, cycle_count} !== 17'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected all zero", {locked, err_pulse, err_code, err_sticky, err_count, cycle_count});
    end
    @(negedge clk_1hz);
    rst = 1'b0;
    apply(2'd1, 4'd1, 0);
    apply(2'd0, 4'd3, 0);
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL relock_after_reset: got %b expected 1", locked); end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_count_mismatch();
    test_illegal_and_state();
    test_saturation();
    test_clr_coincide();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk_1hz);
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d entries expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/traffic_seq_checker.md
TRAFFIC_SEQ_CHECKER -- requirements
Module: traffic_seq_checker

Interface
REQ-001 Parameter RED_COUNT, default 3: load value of countdown on entry to RED.
REQ-002 Parameter GREEN_COUNT, default 4: load value on entry to GREEN.
REQ-003 Parameter YELLOW_COUNT, default 2: load value on entry to YELLOW.
REQ-004 clk_1hz  input  1  sole clock; all sampling and updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 state_in  input  2  observed light state: RED=0, GREEN=1, YELLOW=2, 3 illegal.
REQ-007 countdown_in  input  4  observed countdown value.
REQ-008 clr_err  input  1  synchronous clear of err_sticky and err_count.
REQ-009 locked  output  1  checker is tracking a valid sequence.
REQ-010 err_pulse  output  1  one-cycle flag for a mismatch detected at the previous edge.
REQ-011 err_code  output  2  cause of the last error: 0 none, 1 illegal state, 2 state mismatch, 3 count mismatch.
REQ-012 err_sticky  output  1  set by any error; held until clr_err or rst.
REQ-013 err_count  output  4  error count, saturating at 15.
REQ-014 cycle_count  output  8  completed YELLOW->RED transitions while locked; wraps 255->0.

Function
REQ-015 Every edge SHALL sample state_in and countdown_in; all outputs SHALL be registered, so a response is visible one cycle after the sampling edge.
REQ-016 FSM states SHALL be SYNC and TRACK.
REQ-017 In SYNC, a sample whose state_in is legal and whose countdown_in equals that state's load value SHALL lock: go to TRACK, set locked=1, and form the expected next sample from it.
REQ-018 In SYNC, any other sample SHALL keep SYNC.
REQ-019 In SYNC, no error SHALL be flagged, except state_in=3, which SHALL flag err_code=1.
REQ-020 Expected next sample SHALL be derived from the current expected pair: countdown>0 gives (same state, countdown-1); countdown=0 gives (successor state, successor load value).
REQ-021 State succession SHALL be RED->GREEN->YELLOW->RED.
REQ-022 In TRACK, a sample equal to the expected pair SHALL stay in TRACK and advance the expectation.
REQ-023 In TRACK, a mismatch SHALL return to SYNC, clear locked, assert err_pulse for exactly one cycle, set err_sticky, and increment err_count.
REQ-024 On a mismatch, err_code SHALL use priority illegal state (1) > state mismatch (2) > count mismatch (3).
REQ-025 The mismatching sample SHALL NOT itself be used as a lock candidate in the same edge.
REQ-026 cycle_count SHALL increment when a matched sample in TRACK is (RED, RED_COUNT) and the preceding expected state was YELLOW.
REQ-027 err_count SHALL hold at 15 when further errors occur.
REQ-028 clr_err SHALL clear err_sticky and err_count and set err_code=0.
REQ-029 If clr_err coincides with a new error, the error SHALL win: err_sticky=1, err_count=1, err_code=new cause.
REQ-030 clr_err SHALL NOT affect locked, the FSM, or cycle_count.
REQ-031 countdown_in values above the expected load value SHALL be treated as a count mismatch; no arithmetic SHALL underflow, because decrement occurs only when the expected countdown is >0.

Reset
REQ-032 rst asserted SHALL immediately force: FSM=SYNC, locked=0, err_pulse=0, err_code=0, err_sticky=0, err_count=0, cycle_count=0, expected pair=(RED, RED_COUNT).
REQ-033 rst asserted mid-sequence SHALL discard tracking; relock SHALL follow REQ-017 after release.

Structure
REQ-034 State encodings RED/GREEN/YELLOW, default load counts, and err_code values SHALL live in a shared traffic_pkg package used by the timer and this checker.
REQ-035 Next-expected computation (REQ-020) SHALL be a combinational sub-module traffic_next_expect, reusable by the timer.

Verification
REQ-036 Golden stream R3,R2,R1,R0,G4,...,G0,Y2,Y1,Y0,R3 from reset: locked=1 after the first R3; no err_pulse; cycle_count=1 after the second R3.
REQ-037 Locked, then inject G2 where G3 is expected: err_pulse for one cycle, err_code=3, err_count=1, locked=0; a later G4 relocks.
REQ-038 Locked, then inject state_in=3: err_code=1, err_sticky=1; R1 presented in SYNC does not lock.
REQ-039 Force 17 mismatches: err_count saturates at 15; clr_err pulse gives err_count=0, err_sticky=0.
REQ-040 clr_err asserted on the same edge as a mismatch: err_sticky=1, err_count=1.
REQ-041 Assert rst while locked at G2: all outputs return to reset values asynchronously, before the next edge.
